// File: rtl/subtractor_serial.sv
// Digit-serial unsigned subtractor: diff = a - b, DIGIT bits per cycle, with a start/done handshake.
// Optional feature macro SUBTRACTOR_SERIAL_SAT_EN clamps a borrowing result to zero.
module subtractor_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("subtractor_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   step;
  logic             last;

  // Handshake: start is accepted on any edge where busy is low; done pulses for the one
  // DONE cycle and diff/bout/zero change only on the edge that enters DONE.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign last = (cnt == CW'(NDIG - 1));

  // Top bit of the (DIGIT+1)-bit difference is the borrow out of this digit.
  assign step = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign acc_next = step[DIGIT-1:0];
    end else begin : g_multi
      assign acc_next = {step[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? RUN : IDLE;
      RUN:        state_next = last ? DONE : RUN;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        a_sr   <= a;
        b_sr   <= b;
        acc    <= '0;
        borrow <= 1'b0;
        cnt    <= '0;
      end
    end else begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      acc    <= acc_next;
      borrow <= step[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
`ifdef SUBTRACTOR_SERIAL_SAT_EN
        diff <= step[DIGIT] ? '0 : acc_next;
`else
        diff <= acc_next;
`endif
        bout <= step[DIGIT];
        zero <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial: three instances (8/2, 4/1, 8/8) sharing clock and reset.
module tb_subtractor_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic       start8 = 0, start4 = 0, startf = 0;
  logic [7:0] a8 = 0, b8 = 0, af = 0, bf = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       busy8, done8, bout8, zero8;
  logic       busy4, done4, bout4, zero4;
  logic       busyf, donef, boutf, zerof;
  logic [7:0] diff8, difff;
  logic [3:0] diff4;

  subtractor_serial #(.WIDTH(8), .DIGIT(2)) u_d8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8));

  subtractor_serial #(.WIDTH(4), .DIGIT(1)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4));

  subtractor_serial #(.WIDTH(8), .DIGIT(8)) u_df (
    .clk(clk), .rst(rst), .start(startf), .a(af), .b(bf),
    .busy(busyf), .done(donef), .diff(difff), .bout(boutf), .zero(zerof));

  logic       cur_busy, cur_done, cur_bout, cur_zero;
  logic [7:0] cur_diff;

  always_comb begin
    cur_busy = busy8; cur_done = done8; cur_diff = diff8; cur_bout = bout8; cur_zero = zero8;
    if (sel == 1) begin
      cur_busy = busy4; cur_done = done4; cur_diff = {4'b0, diff4}; cur_bout = bout4; cur_zero = zero4;
    end else if (sel == 2) begin
      cur_busy = busyf; cur_done = donef; cur_diff = difff; cur_bout = boutf; cur_zero = zerof;
    end
  end

  task automatic drive(input int s, input logic st, input logic [7:0] av, input logic [7:0] bv);
    case (s)
      0: begin start8 = st; a8 = av; b8 = bv; end
      1: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; end
      default: begin startf = st; af = av; bf = bv; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the budget).
  task automatic op(input int s, input logic [7:0] av, input logic [7:0] bv,
                    output int lat, output int busy_cnt);
    sel = s;
    drive(s, 1'b1, av, bv);
    @(negedge clk);
    drive(s, 1'b0, 8'h00, 8'h00);
    busy_cnt = cur_busy ? 1 : 0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (cur_done) break;
      if (cur_busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      n_tests++;
      if ({cur_busy, cur_done, cur_diff, cur_bout, cur_zero} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got busy=%b done=%b diff=%0d bout=%b zero=%b, want all 0",
                 s, cur_busy, cur_done, cur_diff, cur_bout, cur_zero);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    op(0, 8'd9, 8'd3, lat, bc);
    n_tests++;
    if (lat !== 4 || bc !== 4) begin
      n_fail++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, want 4 and 4", lat, bc);
    end
    n_tests++;
    if (cur_diff !== 8'd6 || cur_bout !== 1'b0 || cur_zero !== 1'b0 || cur_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got diff=%0d bout=%b zero=%b busy=%b, want 6 0 0 0",
               cur_diff, cur_bout, cur_zero, cur_busy);
    end
    @(negedge clk);
    n_tests++;
    if (cur_done !== 1'b0 || cur_diff !== 8'd6) begin
      n_fail++;
      $display("FAIL done_pulse_hold: got done=%b diff=%0d, want 0 and 6", cur_done, cur_diff);
    end
  endtask

  task automatic test_borrow;
    int lat, bc;
    logic [7:0] exp_diff;
`ifdef SUBTRACTOR_SERIAL_SAT_EN
    exp_diff = 8'h00;
`else
    exp_diff = 8'hFE;
`endif
    op(0, 8'd7, 8'd9, lat, bc);
    n_tests++;
    if (lat !== 4 || cur_diff !== exp_diff || cur_bout !== 1'b1 || cur_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL borrow: got lat=%0d diff=%h bout=%b zero=%b, want 4 %h 1 0",
               lat, cur_diff, cur_bout, cur_zero, exp_diff);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    op(0, 8'd5, 8'd5, lat, bc);
    n_tests++;
    if (lat !== 4 || cur_diff !== 8'd0 || cur_zero !== 1'b1 || cur_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_result: got lat=%0d diff=%0d zero=%b bout=%b, want 4 0 1 0",
               lat, cur_diff, cur_zero, cur_bout);
    end
    op(0, 8'd200, 8'd56, lat, bc);
    n_tests++;
    if (lat !== 4 || cur_diff !== 8'd144 || cur_zero !== 1'b0 || cur_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: got lat=%0d diff=%0d zero=%b bout=%b, want 4 144 0 0",
               lat, cur_diff, cur_zero, cur_bout);
    end
    @(negedge clk);
  endtask

  task automatic test_width4;
    int lat, bc;
    op(1, 8'd12, 8'd6, lat, bc);
    n_tests++;
    if (lat !== 4 || bc !== 4 || cur_diff !== 8'd6 || cur_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL w4_basic: got lat=%0d busy=%0d diff=%0d bout=%b, want 4 4 6 0",
               lat, bc, cur_diff, cur_bout);
    end
    @(negedge clk);
    op(1, 8'd0, 8'd15, lat, bc);
    n_tests++;
    if (lat !== 4 || cur_diff !== 8'd1 || cur_bout !== 1'b1 || cur_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL w4_borrow: got lat=%0d diff=%0d bout=%b zero=%b, want 4 1 1 0",
               lat, cur_diff, cur_bout, cur_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat;
    sel = 0;
    drive(0, 1'b1, 8'd100, 8'd30);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    drive(0, 1'b1, 8'd3, 8'd1);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0);
    lat = 2;
    while (lat < 20 && !cur_done) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 4 || cur_diff !== 8'd70 || cur_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start: got lat=%0d diff=%0d bout=%b, want 4 70 0", lat, cur_diff, cur_bout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int seen;
    sel = 0;
    drive(0, 1'b1, 8'd50, 8'd20);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_diff !== 8'd0 || cur_bout !== 1'b0 || cur_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got busy=%b done=%b diff=%0d bout=%b zero=%b, want all 0",
               cur_busy, cur_done, cur_diff, cur_bout, cur_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cur_done || cur_busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d cycles with done/busy after abort, want 0", seen);
    end
  endtask

  task automatic test_single_digit;
    int lat, bc;
    op(2, 8'h80, 8'h01, lat, bc);
    n_tests++;
    if (lat !== 1 || bc !== 1 || cur_diff !== 8'h7F || cur_bout !== 1'b0 || cur_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL single_digit: got lat=%0d busy=%0d diff=%h bout=%b zero=%b, want 1 1 7f 0 0",
               lat, bc, cur_diff, cur_bout, cur_zero);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_back_to_back;
    test_width4;
    test_ignored_start;
    test_reset_abort;
    test_single_digit;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
